// File: rtl/triangle_monitor_pkg.sv
// Shared types for the triangle waveform generator/monitor pair.
package triangle_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_UP,
        S_DOWN
    } monitor_state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/triangle_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/triangle_monitor.sv
// Checks a 0..MAX..0 triangle stream: tracks direction, flags peaks/troughs,
// measures the trough-to-trough period and reports illegal steps.
module triangle_monitor
    import triangle_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = N + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [N-1:0]  sample,
    output logic          dir,
    output logic          peak,
    output logic          trough,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          locked,
    output logic          error
);

    localparam logic [N-1:0] MAX = '1;

    monitor_state_t r_state;
    logic [N-1:0]   r_prev;
    logic           r_have_trough;
    logic           r_dir;
    logic           r_peak;
    logic           r_trough;
    logic [PW-1:0]  r_period;
    logic           r_period_valid;
    logic           r_locked;
    logic           r_error;

    monitor_state_t w_nxt;
    logic           w_err;
    logic           w_step_up;
    logic           w_step_dn;
    logic           w_peak;
    logic           w_trough;
    logic [PW-1:0]  w_cnt;
    logic [PW-1:0]  w_period_next;
    logic           w_cnt_clr;

    // Guards on prev exclude the MAX<->0 wrap from counting as a unit step.
    assign w_step_up = (r_prev != MAX) && (sample == r_prev + N'(1));
    assign w_step_dn = (r_prev != '0)  && (sample == r_prev - N'(1));

    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        case (r_state)
            S_IDLE: w_nxt = S_ACQUIRE;
            S_ACQUIRE: begin
                if (w_step_up)      w_nxt = S_UP;
                else if (w_step_dn) w_nxt = S_DOWN;
                else                w_err = 1'b1;
            end
            S_UP: begin
                if (w_step_up) begin
                    w_nxt = S_UP;
                end else if ((r_prev == MAX) && w_step_dn) begin
                    w_nxt = S_DOWN;
                end else begin
                    w_nxt = S_ACQUIRE;
                    w_err = 1'b1;
                end
            end
            S_DOWN: begin
                if (w_step_dn) begin
                    w_nxt = S_DOWN;
                end else if ((r_prev == '0) && w_step_up) begin
                    w_nxt = S_UP;
                end else begin
                    w_nxt = S_ACQUIRE;
                    w_err = 1'b1;
                end
            end
            default: begin
                w_nxt = S_ACQUIRE;
                w_err = 1'b1;
            end
        endcase
    end

    // Landing in S_UP/S_DOWN already implies a legal step, and reversals never land on MAX/0.
    assign w_peak   = (w_nxt == S_UP)   && (sample == MAX);
    assign w_trough = (w_nxt == S_DOWN) && (sample == '0);

    assign w_cnt_clr     = ena && (w_err || w_trough);
    assign w_period_next = (w_cnt == '1) ? w_cnt : w_cnt + PW'(1);

    sat_counter #(
        .W (PW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_cnt_clr),
        .inc (ena),
        .q   (w_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_prev         <= '0;
            r_have_trough  <= 1'b0;
            r_dir          <= DIR_DOWN;
            r_peak         <= 1'b0;
            r_trough       <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_peak         <= 1'b0;
            r_trough       <= 1'b0;
            r_period_valid <= 1'b0;
            r_error        <= 1'b0;
            if (ena) begin
                r_state  <= w_nxt;
                r_prev   <= sample;
                r_dir    <= (w_nxt == S_UP) ? DIR_UP : DIR_DOWN;
                r_peak   <= w_peak;
                r_trough <= w_trough;
                r_error  <= w_err;
                if (w_err) begin
                    r_have_trough <= 1'b0;
                    r_locked      <= 1'b0;
                end else if (w_trough) begin
                    r_have_trough <= 1'b1;
                    if (r_have_trough) begin
                        r_period       <= w_period_next;
                        r_period_valid <= 1'b1;
                        r_locked       <= 1'b1;
                    end
                end
            end
        end
    end

    assign dir          = r_dir;
    assign peak         = r_peak;
    assign trough       = r_trough;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign error        = r_error;

endmodule
